// File: rtl/taiko_pkg.sv
// Shared constants and types for the drum-hit judging path: note types,
// judge result encoding and the default hit-window length.
package taiko_pkg;

  localparam logic [1:0] NOTE_DON = 2'd1;
  localparam logic [1:0] NOTE_KA  = 2'd2;

  localparam int unsigned DEFAULT_WINDOW_CYCLES = 8;

  typedef enum logic [1:0] {
    JUDGE_NONE = 2'd0,
    JUDGE_GOOD = 2'd1,
    JUDGE_BAD  = 2'd2,
    JUDGE_MISS = 2'd3
  } judge_e;

  typedef enum logic {
    StIdle,
    StWindow
  } state_e;

  // Pressing both pads at once is always wrong, whatever the note.
  function automatic judge_e classify(logic [1:0] typ, logic hd, logic hk);
    judge_e res;
    if (hd && hk) begin
      res = JUDGE_BAD;
    end else if (hd) begin
      res = (typ == NOTE_DON) ? JUDGE_GOOD : JUDGE_BAD;
    end else begin
      res = (typ == NOTE_KA) ? JUDGE_GOOD : JUDGE_BAD;
    end
    return res;
  endfunction

endpackage

// File: rtl/combo_counter.sv
// Consecutive-GOOD counter for the HUD: synchronous clear wins over increment,
// and the count saturates at all-ones.
module combo_counter #(
  parameter int unsigned COMBO_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               inc_i,
  output logic [COMBO_W-1:0] combo_o
);

  logic [COMBO_W-1:0] combo_q, combo_d;

  always_comb begin
    combo_d = combo_q;
    if (clear_i) begin
      combo_d = '0;
    end else if (inc_i && (combo_q != {COMBO_W{1'b1}})) begin
      combo_d = combo_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      combo_q <= '0;
    end else begin
      combo_q <= combo_d;
    end
  end

  assign combo_o = combo_q;

endmodule

// File: rtl/hit_judge.sv
// Judges drum hits against notes, emitting one registered score pulse per note.
// Optional STRAY_PENALTY_EN: a hit in IDLE without a note is judged BAD.
module hit_judge
  import taiko_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
  parameter int unsigned COMBO_W       = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               round_start,
  input  logic               note_valid,
  input  logic [1:0]         note_type,
  input  logic               hit_don,
  input  logic               hit_ka,
  output logic               increase_score,
  output logic               decrease_score,
  output logic               score_reset,
  output logic [1:0]         judge,
  output logic [COMBO_W-1:0] combo,
  output logic               window_open
);

  localparam logic [7:0] WinLoad = 8'(WINDOW_CYCLES);

  state_e     state_q, state_d;
  logic [1:0] cur_type_q, cur_type_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       inc_q, inc_d;
  logic       dec_q, dec_d;
  logic       srst_q, srst_d;
  judge_e     judge_q, judge_d;

  logic   hit_any, note_ok;
  logic   result_valid;
  judge_e result;
  logic   combo_clr, combo_inc;

  assign hit_any = hit_don | hit_ka;
  assign note_ok = note_valid && ((note_type == NOTE_DON) || (note_type == NOTE_KA));

  always_comb begin
    state_d      = state_q;
    cur_type_d   = cur_type_q;
    wcnt_d       = wcnt_q;
    inc_d        = 1'b0;
    dec_d        = 1'b0;
    srst_d       = 1'b0;
    judge_d      = judge_q;
    result_valid = 1'b0;
    result       = JUDGE_NONE;
    combo_clr    = 1'b0;
    combo_inc    = 1'b0;

    if (round_start) begin
      srst_d    = 1'b1;
      judge_d   = JUDGE_NONE;
      state_d   = StIdle;
      wcnt_d    = '0;
      combo_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (note_ok) begin
            if (hit_any) begin
              // Hit lands on the note's own cycle: judge now, no window needed.
              result_valid = 1'b1;
              result       = classify(note_type, hit_don, hit_ka);
            end else begin
              state_d    = StWindow;
              cur_type_d = note_type;
              wcnt_d     = WinLoad;
            end
          end
`ifdef STRAY_PENALTY_EN
          else if (hit_any) begin
            result_valid = 1'b1;
            result       = JUDGE_BAD;
          end
`endif
        end
        StWindow: begin
          if (note_ok) begin
            // Old note is settled first, then the new one restarts the window.
            result_valid = 1'b1;
            result       = hit_any ? classify(cur_type_q, hit_don, hit_ka) : JUDGE_MISS;
            cur_type_d   = note_type;
            wcnt_d       = WinLoad;
          end else if (hit_any) begin
            result_valid = 1'b1;
            result       = classify(cur_type_q, hit_don, hit_ka);
            state_d      = StIdle;
          end else if (wcnt_q == 8'd1) begin
            result_valid = 1'b1;
            result       = JUDGE_MISS;
            state_d      = StIdle;
          end else begin
            wcnt_d = wcnt_q - 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase

      if (result_valid) begin
        judge_d = result;
        if (result == JUDGE_GOOD) begin
          inc_d     = 1'b1;
          combo_inc = 1'b1;
        end else begin
          dec_d     = 1'b1;
          combo_clr = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cur_type_q <= 2'd0;
      wcnt_q     <= 8'd0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      srst_q     <= 1'b0;
      judge_q    <= JUDGE_NONE;
    end else begin
      state_q    <= state_d;
      cur_type_q <= cur_type_d;
      wcnt_q     <= wcnt_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      srst_q     <= srst_d;
      judge_q    <= judge_d;
    end
  end

  combo_counter #(
    .COMBO_W(COMBO_W)
  ) u_combo (
    .clk_i  (clk),
    .rst_ni (resetn),
    .clear_i(combo_clr),
    .inc_i  (combo_inc),
    .combo_o(combo)
  );

  assign increase_score = inc_q;
  assign decrease_score = dec_q;
  assign score_reset    = srst_q;
  assign judge          = judge_q;
  assign window_open    = (state_q == StWindow);

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: a note/deadline reference model predicts the
// outputs one cycle after each stimulus; a monitor compares them.
module tb_hit_judge;

  localparam int W       = 4;
  localparam int COMBO_W = 2;
  localparam int CMAX    = (1 << COMBO_W) - 1;
  localparam int J_NONE = 0, J_GOOD = 1, J_BAD = 2, J_MISS = 3;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               round_start = 1'b0;
  logic               note_valid = 1'b0;
  logic [1:0]         note_type = 2'd0;
  logic               hit_don = 1'b0;
  logic               hit_ka = 1'b0;
  logic               increase_score, decrease_score, score_reset, window_open;
  logic [1:0]         judge;
  logic [COMBO_W-1:0] combo;

  hit_judge #(
    .WINDOW_CYCLES(W),
    .COMBO_W      (COMBO_W)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .round_start   (round_start),
    .note_valid    (note_valid),
    .note_type     (note_type),
    .hit_don       (hit_don),
    .hit_ka        (hit_ka),
    .increase_score(increase_score),
    .decrease_score(decrease_score),
    .score_reset   (score_reset),
    .judge         (judge),
    .combo         (combo),
    .window_open   (window_open)
  );

  always #5 clk = ~clk;

  typedef struct {
    int inc;
    int dec;
    int srst;
    int jdg;
    int cmb;
    int wopen;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   mon_en = 1'b1;

  // Reference model: a pending note is just "open, its type, and the absolute
  // cycle at which it expires".
  bit m_open = 0;
  int m_type = 0;
  int m_deadline = 0;
  int m_combo = 0;
  int m_judge = 0;
  int cyc = 0;

  task automatic check(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, req);
  endtask

  function automatic int cls(input int typ, input bit hd, input bit hk);
    if (hd && hk) return J_BAD;
    if (hd) return (typ == 1) ? J_GOOD : J_BAD;
    return (typ == 2) ? J_GOOD : J_BAD;
  endfunction

  task automatic drive(input bit rs, input bit nv, input int nt, input bit hd, input bit hk);
    exp_t e;
    int   res;
    bit   nok, hit;
    @(negedge clk);
    round_start = rs;
    note_valid  = nv;
    note_type   = 2'(nt);
    hit_don     = hd;
    hit_ka      = hk;
    res  = -1;
    nok  = nv && (nt == 1 || nt == 2);
    hit  = hd || hk;
    e.inc = 0; e.dec = 0; e.srst = 0;
    if (rs) begin
      e.srst  = 1;
      m_open  = 0;
      m_combo = 0;
      m_judge = J_NONE;
    end else if (m_open) begin
      if (nok) begin
        res        = hit ? cls(m_type, hd, hk) : J_MISS;
        m_type     = nt;
        m_deadline = cyc + W;
      end else if (hit) begin
        res    = cls(m_type, hd, hk);
        m_open = 0;
      end else if (cyc == m_deadline) begin
        res    = J_MISS;
        m_open = 0;
      end
    end else begin
      if (nok) begin
        if (hit) res = cls(nt, hd, hk);
        else begin
          m_open     = 1;
          m_type     = nt;
          m_deadline = cyc + W;
        end
      end else if (hit) begin
`ifdef STRAY_PENALTY_EN
        res = J_BAD;
`endif
      end
    end
    if (res >= 0) begin
      m_judge = res;
      if (res == J_GOOD) begin
        e.inc   = 1;
        m_combo = (m_combo < CMAX) ? m_combo + 1 : CMAX;
      end else begin
        e.dec   = 1;
        m_combo = 0;
      end
    end
    e.jdg   = m_judge;
    e.cmb   = m_combo;
    e.wopen = m_open;
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("increase_score", int'(increase_score), e.inc);
        check("decrease_score", int'(decrease_score), e.dec);
        check("score_reset", int'(score_reset), e.srst);
        check("judge", int'(judge), e.jdg);
        check("combo", int'(combo), e.cmb);
        check("window_open", int'(window_open), e.wopen);
      end
    end
  end

  initial begin : stim
    int waited;
    #2;
    check("reset_inc", int'(increase_score), 0);
    check("reset_dec", int'(decrease_score), 0);
    check("reset_srst", int'(score_reset), 0);
    check("reset_judge", int'(judge), 0);
    check("reset_combo", int'(combo), 0);
    check("reset_window", int'(window_open), 0);
    @(negedge clk);
    resetn = 1'b1;

    // Plan 1: DON at 0, hit_don at 3
    drive(0, 1, 1, 0, 0); idle(2); drive(0, 0, 0, 1, 0); idle(2);
    // Plan 2: KA with no hit -> MISS
    drive(0, 1, 2, 0, 0); idle(6);
    // Plan 3: three GOODs, then BAD
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0); drive(0, 0, 0, 1, 0); idle(1);
    end
    drive(0, 1, 1, 0, 0); drive(0, 0, 0, 0, 1); idle(2);
    // Plan 4: second note replaces the first
    drive(0, 1, 1, 0, 0); idle(1); drive(0, 1, 2, 0, 0); drive(0, 0, 0, 0, 1); idle(2);
    // Plan 5: round_start with a hit during an open window
    drive(0, 1, 1, 0, 0); idle(1); drive(1, 0, 0, 1, 0); idle(2);
    // Plan 6: stray hit, then combo saturation
    drive(0, 0, 0, 1, 0); idle(2);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 2, 0, 0); drive(0, 0, 0, 0, 1);
    end
    // Same-cycle hit, both pads, ignored note types
    drive(0, 1, 1, 1, 0); drive(0, 1, 2, 1, 1); drive(0, 1, 0, 0, 0); drive(0, 1, 3, 0, 1);
    idle(W + 2);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20), $urandom_range(0, 3),
            ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 12));
    end
    idle(W + 2);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #3;
    check("scoreboard_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Async reset in the middle of a window discards the note silently.
    @(negedge clk);
    note_valid = 1'b1; note_type = 2'd1;
    @(posedge clk); #1;
    note_valid = 1'b0; note_type = 2'd0;
    check("window_before_reset", int'(window_open), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("midreset_window", int'(window_open), 0);
    check("midreset_judge", int'(judge), 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      check("post_reset_no_pulse", int'(increase_score | decrease_score), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
Judges drum hits against incoming notes and drives the score counter's increase_score/decrease_score/reset inputs.
- Per note: opens a timing window, classifies the outcome as GOOD, BAD or MISS, and emits exactly one registered score pulse.
- Also tracks a combo (consecutive GOOD count) for the HUD.
- Sits between the note scroller, the drum-pad debouncers and the score counter.

Parameters:
WINDOW_CYCLES, 8, cycles after the note_valid cycle during which a hit is accepted (legal range 1..255)
COMBO_W, 8, combo counter width

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
round_start  input  1  one-cycle pulse: clear score and combo, abandon any open window
note_valid  input  1  one-cycle pulse: a note reaches the hit line
note_type  input  2  qualified by note_valid: 2'd1 DON (red), 2'd2 KA (blue); 0 and 3 are ignored (no window opened)
hit_don  input  1  one-cycle debounced DON pad pulse
hit_ka  input  1  one-cycle debounced KA pad pulse
increase_score  output  1  one-cycle pulse to score counter
decrease_score  output  1  one-cycle pulse to score counter
score_reset  output  1  one-cycle pulse to score counter reset
judge  output  2  last result: 0 NONE, 1 GOOD, 2 BAD, 3 MISS
combo  output  COMBO_W  consecutive GOOD count
window_open  output  1  high while in WINDOW state

Behaviour:
- Reset (resetn low, async): state IDLE, all outputs 0, counter 0. All outputs are registered.
- States: IDLE and WINDOW; 2-bit cur_type register; window counter wcnt (8 bits).
- IDLE:
  - note_valid with valid type: latch type, wcnt <= WINDOW_CYCLES, go WINDOW.
  - A hit in the same cycle as that note_valid is judged against the new note, and the FSM stays IDLE.
- Window span: the note_valid cycle plus WINDOW_CYCLES following cycles.
- WINDOW, evaluated each cycle:
  - Matching hit only: GOOD, go IDLE.
  - Non-matching hit only: BAD, go IDLE.
  - hit_don and hit_ka together: BAD.
  - No hit and wcnt==1: MISS, go IDLE.
  - Otherwise: wcnt decrements.
- New note_valid while in WINDOW:
  - The old note is judged first: by the hit if one arrives this cycle, else MISS.
  - The new note then opens a fresh window (load type, wcnt <= WINDOW_CYCLES, stay WINDOW).
  - There is no queue beyond one note.
- Result timing, one cycle after the deciding edge:
  - GOOD: increase_score=1, combo+1 saturating at all-ones.
  - BAD or MISS: decrease_score=1, combo=0.
  - judge updates to the result and holds until the next result or round_start.
- Hits in IDLE with no note_valid are ignored (see Optional Feature).
- increase_score and decrease_score are never both high.
- round_start has priority over everything:
  - Next cycle: score_reset=1, combo=0, judge=NONE, state IDLE, no score pulse.
  - A note_valid or hit in the same cycle is dropped.
- Reset mid-window: the window is discarded and no pulse is emitted.

Optional Feature:
STRAY_PENALTY_EN
- Defined: a hit (either pad) in IDLE without note_valid produces decrease_score=1 next cycle, judge=BAD, combo=0.
- Undefined: such hits are silently ignored and there is no output change.

Decomposition:
- Shared package taiko_pkg holds:
  - note type constants (NOTE_DON=1, NOTE_KA=2)
  - judge encoding (JUDGE_NONE/GOOD/BAD/MISS)
  - default WINDOW_CYCLES
- One sub-module is natural: combo_counter (clear, inc, saturating, COMBO_W wide).
- The FSM and window timer stay in hit_judge.

Test Plan:
1. WINDOW_CYCLES=4; note_valid type DON at cycle 0, hit_don at cycle 3 -> increase_score pulse at cycle 4, judge=GOOD, combo=1.
2. Note KA at cycle 0, no hits -> decrease_score at cycle 5 (last window cycle 4), judge=MISS, combo=0, window_open low from cycle 5.
3. Three GOODs, then note DON with hit_ka at cycle 1 -> combo 1,2,3, then decrease_score at cycle 2, judge=BAD, combo=0.
4. Note DON, then second note KA 2 cycles later with no hit -> MISS pulse for the first note, window restarts; hit_ka 1 cycle later -> GOOD.
5. round_start during an open window together with hit_don -> score_reset pulse next cycle, no increase_score, combo=0, judge=NONE, IDLE.
6. hit_don in IDLE -> no pulse when STRAY_PENALTY_EN is undefined; decrease_score next cycle when it is defined. Also check COMBO_W=2 saturates at 3 after 5 GOODs.
